// File: rtl/tl_ns_timer.sv
// Next-state logic with a dwell counter for the traffic light loop: reads the registered state q
// and the street sensors, drives d back to the register, and decodes q into the two lights.
module tl_ns_timer #(
    parameter int YELLOW_CYCLES = 5,
    parameter int MIN_GREEN     = 3,
    parameter int MAX_GREEN     = 20,
    parameter int CNT_W         = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ta,
    input  logic             tb,
    input  logic [1:0]       q,
    output logic [1:0]       d,
    output logic [CNT_W-1:0] cnt,
    output logic [1:0]       la,
    output logic [1:0]       lb
);

    // state | meaning
    // S0    | A green, B red
    // S1    | A yellow, B red
    // S2    | B green, A red
    // S3    | B yellow, A red
    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] YEL_TC  = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_TC  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_TC  = CNT_W'(MAX_GREEN - 1);

    state_t           cur;
    state_t           nxt;
    logic [1:0]       q_prev;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_eff;
    logic             min_met;
    logic             max_met;
    logic             yel_done;

    assign cur = state_t'(q);

    // Any change of q restarts the dwell, even one this block did not request.
    assign cnt_eff  = (q != q_prev) ? '0 : cnt_reg;
    assign cnt      = cnt_eff;
    assign min_met  = (cnt_eff >= MIN_TC);
    assign max_met  = (cnt_eff >= MAX_TC);
    assign yel_done = (cnt_eff == YEL_TC);

    always_ff @(posedge clk) begin
        if (reset) begin
            q_prev  <= 2'b00;
            cnt_reg <= '0;
        end else begin
            q_prev  <= q;
            cnt_reg <= (cnt_eff == CNT_MAX) ? CNT_MAX : cnt_eff + CNT_W'(1);
        end
    end

    always_comb begin
        nxt = S0;
        if (!reset) begin
            case (cur)
                S0:      nxt = (min_met && (!ta || (tb && max_met))) ? S1 : S0;
                S1:      nxt = yel_done ? S2 : S1;
                S2:      nxt = (min_met && (!tb || (ta && max_met))) ? S3 : S2;
                S3:      nxt = yel_done ? S0 : S3;
                default: nxt = S0;
            endcase
        end
    end

    assign d = nxt;

    always_comb begin
        la = RED;
        lb = RED;
        case (cur)
            S0:      la = GREEN;
            S1:      la = YELLOW;
            S2:      lb = GREEN;
            S3:      lb = YELLOW;
            default: ;
        endcase
    end

endmodule

// File: doc/tl_ns_timer.md
# tl_ns_timer

Timed next-state stage of the structural traffic light controller. It sits directly upstream of the 2-bit state register. It reads the registered current state `q` and the street sensors, and drives the next state `d` back into that register. It owns a dwell counter that enforces yellow duration, minimum green and maximum green. It also decodes `q` into the two light outputs.

## Interface
Parameters:
- `YELLOW_CYCLES`, 5: clock cycles spent in each yellow state.
- `MIN_GREEN`, 3: minimum cycles in a green state before any exit.
- `MAX_GREEN`, 20: cycles after which a green state yields to waiting cross traffic.
- `CNT_W`, 5: counter width. Constraint: `MAX_GREEN` ≤ 2^CNT_W − 1, and every cycle count is ≥ 1.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset.
- `ta` input 1: traffic present on street A.
- `tb` input 1: traffic present on street B.
- `q` input 2: current state from the downstream register. Encoding: 00 = S0 (A green), 01 = S1 (A yellow), 10 = S2 (B green), 11 = S3 (B yellow).
- `d` output 2: next state to the register.
- `cnt` output CNT_W: effective dwell count in the current state.
- `la` output 2: street A light. 00 = green, 01 = yellow, 10 = red.
- `lb` output 2: street B light, same encoding as `la`.

## Operation
Registers:
- `q_prev` (2 bit) and `cnt_reg` (CNT_W bit).
- On a clock edge with `reset` = 1, both load 0.

Effective count:
- `cnt_eff` = 0 when `q` ≠ `q_prev`; otherwise `cnt_eff` = `cnt_reg`.
- `cnt` output = `cnt_eff`.
- Any change of `q` restarts the count, including a change not issued by this block (for example, an asynchronous reset of the register).

Register update on each edge when `reset` = 0:
- `q_prev` ← `q`.
- `cnt_reg` ← `cnt_eff` + 1, saturating at 2^CNT_W − 1. No wrap-around.

Next-state function (combinational; `d` = 00 whenever `reset` = 1):
- S0:
  - `d` = 01 when `cnt_eff` ≥ MIN_GREEN−1 and either `ta` = 0, or (`tb` = 1 and `cnt_eff` ≥ MAX_GREEN−1).
  - Otherwise `d` = 00.
- S1: `d` = 10 when `cnt_eff` = YELLOW_CYCLES−1; otherwise `d` = 01.
- S2: mirror of S0 with the sensors swapped (`tb` plays the role of `ta`, `ta` the role of `tb`). Exit gives `d` = 11; otherwise `d` = 10.
- S3: `d` = 00 when `cnt_eff` = YELLOW_CYCLES−1; otherwise `d` = 11.

Simultaneous events:
- `ta` = 0 and `tb` = 0 in S0: leave S0 once MIN_GREEN is met. This is the classic rule.
- `ta` = 1 and `tb` = 0: S0 is held indefinitely, and the counter saturates at 31.

Light decode (combinational from `q` only, unaffected by `reset`):
- `la`: 00 in S0, 01 in S1, 10 in S2 and S3.
- `lb`: 10 in S0 and S1, 00 in S2, 01 in S3.

## Timing
- `d`, `cnt`, `la` and `lb` are valid in the same cycle as `q`. The block adds no latency of its own.
- Loop latency: the register loads `d` at the next edge, so each state transition takes one edge.
- Dwell times (measured in cycles during which `q` holds the state):
  - Yellow: exactly YELLOW_CYCLES.
  - Green: at least MIN_GREEN.
  - Green with opposing traffic waiting: at most MAX_GREEN.
- Reset values:
  - During the `reset` cycle: `d` = 00.
  - After the first edge with `reset` = 1: `q_prev` = 00, `cnt_reg` = 0.
  - `la` and `lb` follow `q`.
- Reset mid-operation: the next edge forces the loop to S0 with `cnt_eff` = 0 in the first S0 cycle. No partial yellow is resumed.
- First cycle out of reset with `q` = 00: `cnt_eff` = 0.

## Test plan
The bench closes the loop with a synchronous 2-bit register (`d` → `q`, reset to 00) and uses default parameters.

1. **Reset hold:** `reset` = 1 for 3 cycles with `ta` = 1, `tb` = 1 → `d` = 00 every cycle. After release, `cnt` reads 0,1,2,… from the first cycle.
2. **Minimum green:** release reset with `ta` = 0, `tb` = 0 → `q` = 00 for exactly 3 cycles, `d` = 01 when `cnt` = 2. Then `q` = 01 for exactly 5 cycles with `la` = 01, then `q` = 10 with `la` = 10 and `lb` = 00.
3. **Maximum green:** `ta` = 1, `tb` = 1 → S0 held exactly 20 cycles, `d` = 01 at `cnt` = 19. Then S1 for 5 cycles, then S2 held exactly 20 cycles, then S3.
4. **Saturation:** `ta` = 1, `tb` = 0 for 40 cycles → `q` stays 00, `cnt` saturates at 31 with no wrap. Dropping `ta` → `d` = 01 in that same cycle.
5. **Reset mid-yellow:** assert `reset` in S1 at `cnt` = 2 → `d` = 00 immediately. Next cycle `q` = 00 and `cnt` = 0. The full MIN_GREEN dwell then applies.
6. **Foreign state change:** the bench forces `q` from 00 (at `cnt` = 10) to 11 → `cnt` = 0 in that cycle. S3 lasts 5 cycles, then `q` = 00.
